demux1to16_20bit_reg: RTL and testbench
=======================================

Name: demux1to16_20bit_reg

Overview:
- Registered 1-to-16 demultiplexer for 20-bit words; the inverse of the team's 16-to-1 20-bit mux.
- Steers one input stream to one of 16 output channels, chosen by a 4-bit select.
- Each output channel has a one-entry holding register with a valid/ready handshake, so slow consumers back-pressure only traffic addressed to them.
- Sits between a single producer (e.g. an ALU/datapath result bus) and 16 independent consumers.

Parameters:
- DATA_W, 20, word width in bits.
- NUM_CH, 16, number of output channels; must be 16 in this revision.
- SEL_W, 4, select width; equals clog2(NUM_CH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- in_select  input  SEL_W  destination channel, 0..15.
- in_data  input  DATA_W  word to route.
- cur_select  output  SEL_W  effective destination used this cycle.
- out_valid  output  NUM_CH  per-channel slot-holds-word flag.
- out_ready  input  NUM_CH  per-channel consumer accept.
- out_data  output  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid = 0; all out_data slots = 0; auto-select pointer = 0.
  - in_ready is combinational and therefore reads 1 once out_valid = 0.
- cur_select = in_select (combinational) unless the optional feature is enabled.
- in_ready = !out_valid[cur_select] || out_ready[cur_select]; combinational, and in_valid does not affect it.
- Accept = in_valid && in_ready. On accept, the next edge loads slot[cur_select] with in_data and sets out_valid[cur_select] = 1. Latency is 1 cycle from accept to out_valid.
- Drain = out_valid[k] && out_ready[k]. On drain with no same-cycle accept to slot k, the next edge clears out_valid[k].
- Simultaneous drain and accept on the same slot: the slot takes the new word and out_valid stays 1, giving full throughput of 1 word/cycle per channel.
- Drains on other channels are independent and concurrent; up to 16 drains plus 1 fill can occur per cycle.
- out_data[k] holds its last value after a drain; it is not cleared. Consumers must only sample while out_valid[k] = 1.
- in_data/in_select must be stable while in_valid = 1 and in_ready = 0; the block itself does not register them.
- out_ready on a channel with out_valid = 0 is ignored.
- Reset mid-transfer: any word held in a slot is discarded, and an accept in the same cycle as reset is dropped.
- No state machine beyond per-slot valid bits and the optional pointer.

Optional Feature:
- Macro: DEMUX_AUTO_SEL_EN.
- Defined:
  - in_select is ignored and cur_select = internal pointer.
  - The pointer increments by 1 on each accept, wrapping 15 -> 0, and holds when there is no accept.
  - A blocked destination stalls the input; the pointer never skips a channel.
- Undefined: the pointer is not built and cur_select = in_select.

Decomposition:
- Package demux_pkg:
  - constants DATA_W = 20, NUM_CH = 16, SEL_W = 4;
  - typedef data_t (logic [DATA_W-1:0]);
  - typedef sel_t (logic [SEL_W-1:0]).
- Sub-module demux_slot: one-entry holding register.
  - Inputs: clk, rst_n, wr_en, wr_data, rd_ready.
  - Outputs: valid, data, can_accept.
  - Instantiated NUM_CH times with a generate loop; top level does select decode and in_ready mux.

Test Plan:
- Reset then idle -> out_valid = 16'h0000, out_data all 0, in_ready = 1.
- in_select = 4'd5, in_data = 20'hABCDE, in_valid for 1 cycle, out_ready = 0 -> next cycle out_valid = 16'h0020, channel 5 data = 20'hABCDE; second word to ch5 sees in_ready = 0 and must hold.
- Channel 5 full, out_ready[5] = 1, simultaneous write 20'h12345 to ch5 -> out_valid[5] stays 1 and data becomes 20'h12345; no cycle is lost.
- Back-to-back writes to channels 0..15 with data = 20'h00010*k, all out_ready = 1 -> each channel shows its word exactly 1 cycle after its accept; out_valid drops the cycle after each drain.
- Assert rst_n = 0 while channels 3 and 9 are valid -> next edge out_valid = 0 and data = 0; the concurrent accept is dropped.
- DEMUX_AUTO_SEL_EN build, 17 accepts with in_select tied to 4'd7 -> words land on channels 0,1,...,15,0 (wrap); stalling ch2 (out_ready[2] = 0 while full) holds cur_select = 2 and in_ready = 0.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the registered 1-to-16
// 20-bit demultiplexer.
package demux_pkg;

  localparam int DATA_W = 20;
  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SEL_W-1:0]  sel_t;

endpackage : demux_pkg

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register with a valid/ready output side.
//
// Handshake: a word leaves the slot on a cycle where valid && rd_ready.
// can_accept is high when the slot is empty or is being drained this
// cycle, so a write and a drain may happen on the same edge and the slot
// sustains one word per cycle. wr_en must only be asserted while
// can_accept is high; the top level guarantees that.
module demux_slot
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  data_t wr_data,
  input  logic  rd_ready,
  output logic  valid,
  output data_t data,
  output logic  can_accept
);

  logic  valid_q, valid_d;
  data_t data_q, data_d;

  // Next-state: a write wins over a drain; data holds after a drain.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (wr_en) begin
      valid_d = 1'b1;
      data_d  = wr_data;
    end else if (valid_q && rd_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers; reset discards any held word and clears the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid      = valid_q;
  assign data       = data_q;
  assign can_accept = !valid_q || rd_ready;

endmodule : demux_slot

// File: rtl/demux1to16_20bit_reg.sv
// demux1to16_20bit_reg: steers one 20-bit input stream into one of 16
// output holding slots. Each slot back-pressures only traffic addressed
// to it.
//
// Input handshake: a word is taken on a cycle where in_valid && in_ready.
// in_ready depends only on the slot selected by cur_select, never on
// in_valid. in_data/in_select must be held by the producer while
// in_valid is high and in_ready is low.
//
// Build option DEMUX_AUTO_SEL_EN: when defined, in_select is ignored and
// an internal round-robin pointer (advancing by one per accepted word,
// wrapping 15 -> 0) chooses the destination. A blocked destination stalls
// the input; the pointer never skips a channel.
module demux1to16_20bit_reg
  import demux_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_select,
  input  logic [DATA_W-1:0]        in_data,
  output logic [SEL_W-1:0]         cur_select,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data
);

  logic [NUM_CH-1:0] slot_can_accept;
  logic [NUM_CH-1:0] slot_wr_en;
  logic              accept;

`ifdef DEMUX_AUTO_SEL_EN
  sel_t ptr_q, ptr_d;

  // Pointer advances only when a word is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = ptr_q + sel_t'(1);
  end

  // Round-robin destination pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign cur_select = ptr_q;
`else
  assign cur_select = in_select;
`endif

  assign in_ready = slot_can_accept[cur_select];
  assign accept   = in_valid && in_ready;

  // One-hot write enable for the selected slot on accept.
  always_comb begin
    slot_wr_en = '0;
    if (accept) slot_wr_en[cur_select] = 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (slot_wr_en[k]),
      .wr_data    (in_data),
      .rd_ready   (out_ready[k]),
      .valid      (out_valid[k]),
      .data       (out_data[k*DATA_W +: DATA_W]),
      .can_accept (slot_can_accept[k])
    );
  end

endmodule : demux1to16_20bit_reg

// File: tb/tb_demux1to16_20bit_reg.sv
// Testbench for demux1to16_20bit_reg (default build or DEMUX_AUTO_SEL_EN).
module tb_demux1to16_20bit_reg;

  localparam int DW = 20;
  localparam int NC = 16;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_select;
  logic [DW-1:0]  in_data;
  logic [3:0]     cur_select;
  logic [NC-1:0]  out_valid;
  logic [NC-1:0]  out_ready;
  logic [NC*DW-1:0] out_data;

  int tests_run;
  int tests_failed;

  // Reference state: what each channel holds, and the auto pointer.
  logic          m_valid [NC];
  logic [DW-1:0] m_data  [NC];
  logic [3:0]    m_ptr;

  demux1to16_20bit_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_select  (in_select),
    .in_data    (in_data),
    .cur_select (cur_select),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_dest(input logic [3:0] sel);
`ifdef DEMUX_AUTO_SEL_EN
    return m_ptr;
`else
    return sel;
`endif
  endfunction

  // Compare every channel's flag and data with the reference.
  task automatic check_outputs();
    logic [NC-1:0] ev;
    for (int k = 0; k < NC; k++) ev[k] = m_valid[k];
    chk("out_valid", 32'(out_valid), 32'(ev));
    for (int k = 0; k < NC; k++)
      chk($sformatf("out_data[%0d]", k), 32'(out_data[k*DW +: DW]), 32'(m_data[k]));
  endtask

  // One clock of traffic: drive, check the combinational side, clock,
  // advance the reference, then check the registered side.
  task automatic step(input logic v, input logic [3:0] s, input logic [DW-1:0] d,
                      input logic [NC-1:0] r);
    logic [3:0] dest;
    logic       rdy;
    in_valid  = v;
    in_select = s;
    in_data   = d;
    out_ready = r;
    #1;
    dest = model_dest(s);
    rdy  = !m_valid[dest] || r[dest];
    chk("cur_select", 32'(cur_select), 32'(dest));
    chk("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk);
    for (int k = 0; k < NC; k++) begin
      if (v && rdy && (k == int'(dest))) begin
        m_valid[k] = 1'b1;
        m_data[k]  = d;
      end else if (m_valid[k] && r[k]) begin
        m_valid[k] = 1'b0;
      end
    end
    if (v && rdy) m_ptr = m_ptr + 4'd1;
    @(negedge clk);
    check_outputs();
  endtask

  // Reset for one edge while optionally offering a word that must be dropped.
  task automatic do_reset(input logic v, input logic [3:0] s, input logic [DW-1:0] d);
    rst_n     = 1'b0;
    in_valid  = v;
    in_select = s;
    in_data   = d;
    out_ready = '0;
    @(posedge clk);
    for (int k = 0; k < NC; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
    end
    m_ptr = 4'd0;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_select = 4'd0;
    #1;
    check_outputs();
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_select = '0;
    in_data   = '0;
    out_ready = '0;
    m_ptr     = '0;
    for (int k = 0; k < NC; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset then idle
    do_reset(1'b0, 4'd0, '0);

`ifndef DEMUX_AUTO_SEL_EN
    // Single word to channel 5, consumer not ready
    step(1'b1, 4'd5, 20'hABCDE, 16'h0000);
    chk("ch5_valid_only", 32'(out_valid), 32'h0020);
    chk("ch5_data", 32'(out_data[5*DW +: DW]), 32'h0ABCDE);
    // Second word to full channel 5 must be refused and held
    step(1'b1, 4'd5, 20'h11111, 16'h0000);
    chk("ch5_still_first", 32'(out_data[5*DW +: DW]), 32'h0ABCDE);
    // Simultaneous drain and fill on channel 5
    step(1'b1, 4'd5, 20'h12345, 16'h0020);
    chk("ch5_refill_valid", 32'(out_valid[5]), 32'd1);
    chk("ch5_refill_data", 32'(out_data[5*DW +: DW]), 32'h012345);
    step(1'b0, 4'd5, '0, 16'hFFFF);

    // Back-to-back writes to every channel with consumers always ready
    for (int k = 0; k < NC; k++) begin
      step(1'b1, 4'(k), 20'(32'h10 * k), 16'hFFFF);
      chk("b2b_onehot", 32'(out_valid), 32'(1) << k);
    end
    step(1'b0, 4'd0, '0, 16'hFFFF);
    chk("b2b_drained", 32'(out_valid), 32'h0);

    // Reset while channels 3 and 9 hold words; concurrent accept dropped
    step(1'b1, 4'd3, 20'h33333, 16'h0000);
    step(1'b1, 4'd9, 20'h99999, 16'h0000);
    chk("pre_reset_valid", 32'(out_valid), 32'h0208);
    do_reset(1'b1, 4'd4, 20'h44444);
    chk("post_reset_ch4", 32'(out_data[4*DW +: DW]), 32'h0);
`else
    // Auto-select: 17 accepts with in_select tied to 7 land on 0..15,0
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 4'd7, 20'(32'h100 + i), 16'hFFFF);
      chk("auto_onehot", 32'(out_valid), 32'(1) << (i % 16));
    end
    chk("auto_wrap_data", 32'(out_data[0 +: DW]), 32'h000110);
    step(1'b0, 4'd7, '0, 16'hFFFF);

    // Stall on channel 2: its consumer is not ready while it is full
    do_reset(1'b0, 4'd0, '0);
    for (int i = 0; i < 18; i++)
      step(1'b1, 4'd7, 20'(32'h200 + i), 16'hFFFB);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'd7, 20'h2FFFF, 16'hFFFB);
      chk("stall_cur_select", 32'(cur_select), 32'd2);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    chk("stall_ch2_data", 32'(out_data[2*DW +: DW]), 32'h000202);
    step(1'b1, 4'd7, 20'h2AAAA, 16'hFFFF);
    chk("unstall_ch2_data", 32'(out_data[2*DW +: DW]), 32'h02AAAA);
    do_reset(1'b1, 4'd1, 20'h55555);
`endif

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)),
           20'($urandom),
           16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_demux1to16_20bit_reg
